// File: rtl/cpu86_exec_retire_tracker.sv
// ---------------------------------------------------------------------------
// cpu86_exec_retire_tracker
//
// In-order retirement tracker sitting between the CPU86 issue point and the
// exec-stage register file. Each issued instruction's static info (op, dir,
// code, CS:IP, sreg, dreg) is queued in a circular buffer. On every retire
// pulse the oldest entry is popped. Next cycle it is presented as a vld_*
// record, together with the architectural registers sampled in the retire
// cycle. The record feeds the golden-reference register checker.
//
// Parameters:
//   DEPTH  in-flight queue depth (power of two, 2..16)
//   CNT_W  width of the retired-instruction counter
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   issue_*              issue handshake and static instruction fields
//   issue_ready          combinational: (count < DEPTH) && !flush
//   retire_valid         oldest in-flight instruction retired this cycle
//   flush                discard all in-flight entries (branch redirect)
//   rf_ax..rf_fl         architectural registers, valid in the retire cycle
//   vld_valid            one-cycle pulse per emitted retire record
//   vld_*                head-entry fields plus sampled registers (held)
//   retire_cnt           retired instructions since reset (wraps)
//   err_underflow        sticky: retire seen with an empty queue
//
// Optional feature macro: CPU86_TRACE_PREFIX_FILTER_EN
//   When defined, retired PREFIX entries (op=11) with code LOCK (2) or
//   SEGM (3) are popped and counted but produce no vld_valid pulse.
// ---------------------------------------------------------------------------
module cpu86_exec_retire_tracker #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [4:0]       issue_op,
   input  logic [2:0]       issue_dir,
   input  logic [3:0]       issue_code,
   input  logic [15:0]      issue_cs,
   input  logic [15:0]      issue_ip,
   input  logic [3:0]       issue_sreg,
   input  logic [3:0]       issue_dreg,
   input  logic             retire_valid,
   input  logic             flush,
   input  logic [15:0]      rf_ax,
   input  logic [15:0]      rf_bx,
   input  logic [15:0]      rf_cx,
   input  logic [15:0]      rf_dx,
   input  logic [15:0]      rf_bp,
   input  logic [15:0]      rf_sp,
   input  logic [15:0]      rf_si,
   input  logic [15:0]      rf_di,
   input  logic [15:0]      rf_fl,
   output logic             vld_valid,
   output logic [4:0]       vld_op,
   output logic [2:0]       vld_dir,
   output logic [3:0]       vld_code,
   output logic [15:0]      vld_cs,
   output logic [15:0]      vld_ip,
   output logic [3:0]       vld_sreg,
   output logic [3:0]       vld_dreg,
   output logic [15:0]      vld_ax,
   output logic [15:0]      vld_bx,
   output logic [15:0]      vld_cx,
   output logic [15:0]      vld_dx,
   output logic [15:0]      vld_bp,
   output logic [15:0]      vld_sp,
   output logic [15:0]      vld_si,
   output logic [15:0]      vld_di,
   output logic [15:0]      vld_fl,
   output logic [CNT_W-1:0] retire_cnt,
   output logic             err_underflow
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          EW      = 52;
   localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

   // Entry layout: {op[51:47], dir[46:44], code[43:40], cs[39:24],
   //                ip[23:8], sreg[7:4], dreg[3:0]}
   logic [EW-1:0]      r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_count;

   logic               r_vld_valid;
   logic [EW-1:0]      r_vld_entry;
   logic [8:0][15:0]   r_vld_rf;
   logic [CNT_W-1:0]   r_retire_cnt;
   logic               r_err_underflow;

   logic               w_issue_ready;
   logic               w_push;
   logic               w_pop;
   logic               w_filt;
   logic               w_emit;
   logic [EW-1:0]      w_issue_entry;
   logic [EW-1:0]      w_head;
   logic [8:0][15:0]   w_rf;

   // Ready is refused during a flush and is not helped by a same-cycle retire.
   assign w_issue_ready = (r_count < L_DEPTH) && !flush;
   assign w_push        = issue_valid && w_issue_ready;
   assign w_pop         = retire_valid && (r_count != '0);

   assign w_issue_entry = {issue_op, issue_dir, issue_code, issue_cs,
                           issue_ip, issue_sreg, issue_dreg};
   assign w_head        = r_mem[r_rd_ptr];
   assign w_rf          = {rf_fl, rf_di, rf_si, rf_sp, rf_bp,
                           rf_dx, rf_cx, rf_bx, rf_ax};

`ifdef CPU86_TRACE_PREFIX_FILTER_EN
   // LOCK / segment-override prefixes carry no architectural effect of their
   // own, so the checker never sees them. REPZ/REPNZ are still emitted.
   assign w_filt = (w_head[51:47] == 5'd11) &&
                   ((w_head[43:40] == 4'b0010) || (w_head[43:40] == 4'b0011));
`else
   assign w_filt = 1'b0;
`endif

   assign w_emit = w_pop && !w_filt;

   // Payload storage needs no reset: only slots between rd_ptr and wr_ptr
   // are ever read.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_issue_entry;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // A flush refuses the issue (ready=0), so wr_ptr is stable and the
         // same-cycle pop is subsumed by snapping rd_ptr to wr_ptr.
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
         end else begin
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
               r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_pop)
               r_count <= r_count - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_vld_valid     <= 1'b0;
         r_vld_entry     <= '0;
         r_vld_rf        <= '0;
         r_retire_cnt    <= '0;
         r_err_underflow <= 1'b0;
      end else begin
         r_vld_valid <= w_emit;
         if (w_emit) begin
            r_vld_entry <= w_head;
            r_vld_rf    <= w_rf;
         end
         if (w_pop)
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
         if (retire_valid && (r_count == '0))
            r_err_underflow <= 1'b1;
      end
   end

   assign issue_ready   = w_issue_ready;
   assign vld_valid     = r_vld_valid;
   assign vld_op        = r_vld_entry[51:47];
   assign vld_dir       = r_vld_entry[46:44];
   assign vld_code      = r_vld_entry[43:40];
   assign vld_cs        = r_vld_entry[39:24];
   assign vld_ip        = r_vld_entry[23:8];
   assign vld_sreg      = r_vld_entry[7:4];
   assign vld_dreg      = r_vld_entry[3:0];
   assign vld_ax        = r_vld_rf[0];
   assign vld_bx        = r_vld_rf[1];
   assign vld_cx        = r_vld_rf[2];
   assign vld_dx        = r_vld_rf[3];
   assign vld_bp        = r_vld_rf[4];
   assign vld_sp        = r_vld_rf[5];
   assign vld_si        = r_vld_rf[6];
   assign vld_di        = r_vld_rf[7];
   assign vld_fl        = r_vld_rf[8];
   assign retire_cnt    = r_retire_cnt;
   assign err_underflow = r_err_underflow;

endmodule
